// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, constants and helpers
package fft_pkg;

    localparam int N_POINT = 16;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx64_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_LAUNCH  = 2'd2
    } fc_state_e;

    // Caller supplies the sample already sign-extended to 32 bits.
    function automatic cplx64_t sext_to_cplx(input logic signed [31:0] sample);
        cplx64_t c;
        c.re = sample;
        c.im = '0;
        return c;
    endfunction

endpackage

// File: rtl/fft_frame_collector.sv
// rtl/fft_frame_collector.sv - assembles 16-sample frames and launches the FFT
module fft_frame_collector #(
    parameter int SAMPLE_W = 16,
    parameter int N_POINT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_valid,
    input  logic                i_ready,
    output logic [63:0]         a_o,
    output logic [63:0]         b_o,
    output logic [63:0]         c_o,
    output logic [63:0]         d_o,
    output logic [63:0]         e_o,
    output logic [63:0]         f_o,
    output logic [63:0]         g_o,
    output logic [63:0]         h_o,
    output logic [63:0]         i_o,
    output logic [63:0]         j_o,
    output logic [63:0]         k_o,
    output logic [63:0]         l_o,
    output logic [63:0]         m_o,
    output logic [63:0]         n_o,
    output logic [63:0]         o_o,
    output logic [63:0]         p_o,
    output logic                o_start,
    output logic                o_overflow,
    output logic [3:0]          o_fill
);
    import fft_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(N_POINT - 1);

    logic [SAMPLE_W-1:0] fill_q [N_POINT];
    cplx64_t             frame_q [N_POINT];
    logic [3:0]          wr_idx_q, wr_idx_d;
    fc_state_e           state_q, state_d;
    logic                overflow_q, overflow_d;
    logic                pending;
    logic                blocked;
    logic                complete;
    logic                load;

    function automatic cplx64_t to_word(input logic [SAMPLE_W-1:0] s);
        return sext_to_cplx(32'($signed(s)));
    endfunction

    assign complete = i_valid && (wr_idx_q == LAST_IDX);
    assign load     = complete && !blocked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A completion in PENDING or LAUNCH is dropped, so LAUNCH never goes straight back to PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:   if (load)    state_d = ST_PENDING;
            ST_PENDING: if (i_ready) state_d = ST_LAUNCH;
            ST_LAUNCH:               state_d = ST_EMPTY;
            default:                 state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        pending = 1'b0;
        o_start = 1'b0;
        case (state_q)
            ST_PENDING: pending = 1'b1;
            ST_LAUNCH:  o_start = 1'b1;
            default:    ;
        endcase
        blocked = pending | o_start;
    end

    always_comb begin
        wr_idx_d   = i_valid ? wr_idx_q + 4'd1 : wr_idx_q;
        overflow_d = overflow_q | (complete & blocked);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_POINT; i++) begin
                fill_q[i] <= '0;
            end
        end else if (i_valid) begin
            fill_q[wr_idx_q] <= i_sample;
        end
    end

    // The last slot bypasses the fill buffer so the frame is ready the same edge it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_POINT; i++) begin
                frame_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_POINT - 1; i++) begin
                frame_q[i] <= to_word(fill_q[i]);
            end
            frame_q[N_POINT-1] <= to_word(i_sample);
        end
    end

    assign o_overflow = overflow_q;
    assign o_fill     = wr_idx_q;

    assign a_o = frame_q[0];
    assign b_o = frame_q[1];
    assign c_o = frame_q[2];
    assign d_o = frame_q[3];
    assign e_o = frame_q[4];
    assign f_o = frame_q[5];
    assign g_o = frame_q[6];
    assign h_o = frame_q[7];
    assign i_o = frame_q[8];
    assign j_o = frame_q[9];
    assign k_o = frame_q[10];
    assign l_o = frame_q[11];
    assign m_o = frame_q[12];
    assign n_o = frame_q[13];
    assign o_o = frame_q[14];
    assign p_o = frame_q[15];

endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Upstream framing stage for the 16-point FFT. It accepts a stream of signed 16-bit audio samples and assembles them into non-overlapping 16-sample frames. Each completed frame is presented as 16 parallel 64-bit complex words {real[31:0], imag[31:0]} on ports `a_o`..`p_o`, which wire directly to the FFT's `a_i`..`p_i`. A one-cycle `o_start` pulse launches the FFT, and the frame is held stable for as long as the FFT needs to read it.

## Interface
Parameters:
- `SAMPLE_W`, default 16: input sample width; sign-extended to 32 bits on output.
- `N_POINT`, default 16: frame length. Fixed at 16; other values are unsupported.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `i_sample`, input, `SAMPLE_W`: signed PCM sample.
- `i_valid`, input, 1: `i_sample` is accepted on every rising edge where this is 1. There is no back-pressure.
- `i_ready`, input, 1: the downstream FFT can take a new frame. Tie to 1 if unused.
- `a_o`..`p_o`, output, 64 each: frame words x0..x15 in natural order. Each word is `{sext32(sample), 32'h0}`.
- `o_start`, output, 1: single-cycle frame launch pulse.
- `o_overflow`, output, 1: sticky flag; a completed frame was dropped.
- `o_fill`, output, 4: index of the next sample slot to be written.

## Operation
- **Fill buffer:** 16 × `SAMPLE_W` registers plus a 4-bit write index `wr_idx`.
  - On `i_valid`, `i_sample` is written to `fill[wr_idx]` and `wr_idx` increments.
  - `wr_idx` wraps from 15 to 0.
- **Frame completion:** an accepted sample with `wr_idx==15`.
- **Output frame registers:** 16 × 64 bits, loaded only at completion and only when the block is not blocked, where `blocked = pending | o_start`.
  - The load takes `fill[0..14]` plus the current `i_sample` as x15.
  - Real part = sign-extend to 32 bits; imaginary part = 0.
  - On load, `pending` is set to 1.
- **Blocked at completion:** the frame is discarded and `o_overflow` is set to 1. `o_overflow` clears only on reset.
  - The output frame registers and `pending` are unchanged.
  - `wr_idx` still wraps to 0, so sample alignment is preserved.
- **Launch:** when `pending & i_ready` at an edge, `o_start` is 1 for the next cycle only and `pending` clears.
- **State machine:**
  - States: EMPTY (`pending=0`, `o_start=0`), PENDING (`pending=1`), LAUNCH (`o_start=1`).
  - EMPTY → PENDING on completion.
  - PENDING → LAUNCH on `i_ready`.
  - LAUNCH → EMPTY unconditionally.
  - LAUNCH → PENDING is not possible, because completion is blocked in LAUNCH.
- **Simultaneous completion and launch (PENDING with `i_ready`):** completion is blocked, so the new frame is dropped and overflow is set. It is not queued.
- **Reset:** the fill buffer, output frame registers, `wr_idx`, `pending`, `o_start` and `o_overflow` are all 0, so `a_o`..`p_o` are 0.
  - Reset asserted mid-frame discards any partial frame.
  - Reset asserted during LAUNCH cancels the pulse immediately, since reset is asynchronous.

## Timing
- **Cycle n:** the 16th sample is accepted. At the end of cycle n the frame is loaded and `pending=1`.
- **Cycle n+1:** if `i_ready=1`, then `o_start=1` in cycle n+2.
  - Minimum latency from the last sample to `o_start` is 2 cycles.
- **Frame stability:** `a_o`..`p_o` are constant from the end of cycle n until the next successful load.
  - The earliest next load is at the end of cycle n+3, one cycle after `o_start`.
  - This covers the FFT's start-then-RUN read in cycle n+3.
- **Continuous input:** with `i_valid` held at 1 and `i_ready` at 1, one frame is produced every 16 cycles and overflow never occurs.
- **Combinational paths:** `o_start`, `o_overflow` and `o_fill` are all registered, so there is no combinational path from input to output.

## Structure
- **Shared package `fft_pkg`:**
  - `localparam N_POINT = 16`.
  - typedef `cplx64_t`, a packed struct `{logic signed [31:0] re; logic signed [31:0] im;}`.
  - function `sext_to_cplx(sample)`.
  - The FFT stages use the same package.
- **No sub-module.** This is a single module: fill buffer, index counter, three-state control and frame register bank.
  - The frame register bank is a `cplx64_t` array flattened onto `a_o`..`p_o`.

## Test plan
- **Ramp with ready high:** reset, then drive samples 1..16 with `i_valid=1` and `i_ready=1` → `o_start` high exactly 2 cycles after sample 16. `a_o=64'h00000001_00000000`, `p_o=64'h00000010_00000000`. `o_overflow=0`.
- **Negative sign extension:** drive the frame `16'h8000`, `16'hFFFF`, then 0 ×14 → `a_o=64'hFFFF8000_00000000`, `b_o=64'hFFFFFFFF_00000000`.
- **Held-off launch, then overflow:**
  - Hold `i_ready=0`, send 32 samples. The first frame stays on the outputs unchanged.
  - At sample 32, `o_overflow` rises and `o_fill=0`.
  - Raise `i_ready` → a single `o_start` pulse carrying frame 1's data.
- **Gapped input:** `i_valid` toggles 1/0 over 32 cycles → one frame, `o_start` 2 cycles after the 16th accepted sample, `o_fill` tracks only accepted samples.
- **Reset mid-frame:** after 7 samples, pulse `rst` low → all outputs 0 asynchronously. The next 16 samples form a clean frame starting at x0 = the first post-reset sample.
- **Back-to-back frames with `i_ready=1`:** 64 continuous samples → 4 `o_start` pulses spaced 16 cycles apart, each frame stable from its load until the next load, `o_overflow=0`.
